// File: rtl/duck_pkg.sv
// Shared types and sprite geometry for the duck sprite sequencer.
//   duck_state_t : duck life-cycle states, exported on duck_sprite_ctrl.state
//   SPRITE_W/H   : sprite box size in pixels
//   NUM_FRAMES   : animation frames in the duck ROM set
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLY    = 3'd1,
    HIT    = 3'd2,
    FALL   = 3'd3,
    ESCAPE = 3'd4
  } duck_state_t;

  localparam int unsigned SPRITE_W   = 64;
  localparam int unsigned SPRITE_H   = 64;
  localparam int unsigned NUM_FRAMES = 4;

endpackage

// File: rtl/duck_pixel_pipe.sv
// Pixel path for the duck sprite: box test, ROM address generation and
// alignment of the in-box flag with the 1-cycle ROM read.
//   clock, reset          : system clock, synchronous active-high reset
//   active                : duck is visible (not IDLE)
//   draw_x, draw_y        : current pixel coordinate
//   duck_x, duck_y        : sprite top-left corner
//   rom_q                 : colour index returned one cycle after rom_address
//   rom_address           : {2'b00, row, col} within the sprite
//   pixel_on, pixel_idx   : opaque flag and index, 2 cycles after draw_x/draw_y
module duck_pixel_pipe
  import duck_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        active,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  duck_x,
  input  logic [9:0]  duck_y,
  input  logic [3:0]  rom_q,
  output logic [13:0] rom_address,
  output logic        pixel_on,
  output logic [3:0]  pixel_idx
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic        in_box_q;
  logic        pixel_on_d;

  // A pixel left of / above the sprite wraps to a large unsigned value,
  // so one unsigned compare per axis covers both edges.
  assign dx = {1'b0, draw_x} - {1'b0, duck_x};
  assign dy = {1'b0, draw_y} - {1'b0, duck_y};

  assign in_box      = active && (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
  assign rom_address = {2'b00, dy[5:0], dx[5:0]};
  assign pixel_on_d  = in_box_q && (rom_q != 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      in_box_q  <= 1'b0;
      pixel_on  <= 1'b0;
      pixel_idx <= 4'd0;
    end else begin
      in_box_q  <= in_box;
      pixel_on  <= pixel_on_d;
      pixel_idx <= pixel_on_d ? rom_q : 4'd0;
    end
  end

endmodule

// File: rtl/duck_sprite_ctrl.sv
// Duck sprite sequencer: state machine, screen position, animation frame and
// the pixel path feeding the colour mapper.
//   clock, reset      : system clock, synchronous active-high reset
//   frame_tick        : one pulse per video frame; all motion happens on it
//   start, shot       : launch (IDLE only) and hit (FLY only) requests
//   draw_x, draw_y    : current pixel coordinate
//   rom_q             : duck ROM colour index, 1 cycle after rom_address
//   rom_frame         : ROM frame select 0..3
//   rom_address       : ROM address within the selected frame
//   pixel_on/idx      : duck pixel opaque flag and colour index
//   duck_x, duck_y    : sprite top-left corner
//   state             : current duck state
//   fell, escaped     : one-cycle pulses on returning to IDLE
module duck_sprite_ctrl
  import duck_pkg::*;
#(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned GROUND_Y     = 400,
  parameter int unsigned START_X      = 64,
  parameter int unsigned START_Y      = 336,
  parameter int unsigned ANIM_DIV     = 6,
  parameter int unsigned FLY_DX       = 2,
  parameter int unsigned FLY_DY       = 1,
  parameter int unsigned FALL_DY      = 4,
  parameter int unsigned HIT_TICKS    = 30,
  parameter int unsigned ESCAPE_TICKS = 600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        shot,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [3:0]  rom_q,
  output logic [4:0]  rom_frame,
  output logic [13:0] rom_address,
  output logic        pixel_on,
  output logic [3:0]  pixel_idx,
  output logic [9:0]  duck_x,
  output logic [9:0]  duck_y,
  output duck_state_t state,
  output logic        fell,
  output logic        escaped
);

  localparam logic signed [10:0] FlyDx   = 11'(FLY_DX);
  localparam logic signed [10:0] XMax    = 11'(SCREEN_W - SPRITE_W);
  localparam logic [9:0]         FlyDy   = 10'(FLY_DY);
  localparam logic [9:0]         FallDy  = 10'(FALL_DY);
  localparam logic [10:0]        GroundY = 11'(GROUND_Y);
  localparam logic [9:0]         StartX  = 10'(START_X);
  localparam logic [9:0]         StartY  = 10'(START_Y);
  localparam logic [15:0]        AnimLast = 16'(ANIM_DIV - 1);
  localparam logic [15:0]        EscLast  = 16'(ESCAPE_TICKS - 1);
  localparam logic [15:0]        HitLast  = 16'(HIT_TICKS - 1);

  duck_state_t state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dir_left_q, dir_left_d;
  logic [1:0]  frame_q, frame_d;
  logic [15:0] anim_q, anim_d;
  logic [15:0] esc_q, esc_d;
  logic [15:0] hit_q, hit_d;
  logic        fell_q, fell_d;
  logic        escaped_q, escaped_d;

  logic signed [10:0] x_step;
  logic [9:0]         y_fly;
  logic [9:0]         y_rise;
  logic [10:0]        y_fall;
  logic [15:0]        anim_next;
  logic [1:0]         frame_next;

  // Candidate per-tick updates; the FSM picks which ones apply.
  always_comb begin
    x_step = dir_left_q ? (signed'({1'b0, x_q}) - FlyDx) : (signed'({1'b0, x_q}) + FlyDx);
    y_fly  = (y_q >= FlyDy) ? (y_q - FlyDy) : 10'd0;
    y_rise = (y_q >= FallDy) ? (y_q - FallDy) : 10'd0;
    y_fall = {1'b0, y_q} + {1'b0, FallDy};
    if (y_fall >= GroundY) begin
      y_fall = GroundY;
    end
    if (anim_q == AnimLast) begin
      anim_next  = 16'd0;
      frame_next = frame_q + 2'd1;
    end else begin
      anim_next  = anim_q + 16'd1;
      frame_next = frame_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_left_d = dir_left_q;
    frame_d    = frame_q;
    anim_d     = anim_q;
    esc_d      = esc_q;
    hit_d      = hit_q;
    fell_d     = 1'b0;
    escaped_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FLY;
          x_d        = StartX;
          y_d        = StartY;
          dir_left_d = 1'b0;
          frame_d    = 2'd0;
          anim_d     = 16'd0;
          esc_d      = 16'd0;
          hit_d      = 16'd0;
        end
      end
      FLY: begin
        // A shot in the same cycle as a tick suppresses that tick's motion.
        if (shot) begin
          state_d = HIT;
          hit_d   = 16'd0;
        end else if (frame_tick) begin
          // Reaching either wall turns the duck so the next tick moves away.
          if (x_step >= XMax) begin
            x_d        = XMax[9:0];
            dir_left_d = 1'b1;
          end else if (x_step <= 11'sd0) begin
            x_d        = 10'd0;
            dir_left_d = 1'b0;
          end else begin
            x_d = x_step[9:0];
          end
          y_d     = y_fly;
          anim_d  = anim_next;
          frame_d = frame_next;
          esc_d   = esc_q + 16'd1;
          if (esc_q == EscLast) begin
            state_d = ESCAPE;
          end
        end
      end
      HIT: begin
        if (frame_tick) begin
          if (hit_q == HitLast) begin
            state_d = FALL;
          end else begin
            hit_d = hit_q + 16'd1;
          end
        end
      end
      FALL: begin
        if (frame_tick) begin
          y_d = y_fall[9:0];
          if (y_fall >= GroundY) begin
            state_d = IDLE;
            fell_d  = 1'b1;
          end
        end
      end
      ESCAPE: begin
        if (frame_tick) begin
          y_d     = y_rise;
          anim_d  = anim_next;
          frame_d = frame_next;
          if (y_rise == 10'd0) begin
            state_d   = IDLE;
            escaped_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= StartX;
      y_q        <= StartY;
      dir_left_q <= 1'b0;
      frame_q    <= 2'd0;
      anim_q     <= 16'd0;
      esc_q      <= 16'd0;
      hit_q      <= 16'd0;
      fell_q     <= 1'b0;
      escaped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_left_q <= dir_left_d;
      frame_q    <= frame_d;
      anim_q     <= anim_d;
      esc_q      <= esc_d;
      hit_q      <= hit_d;
      fell_q     <= fell_d;
      escaped_q  <= escaped_d;
    end
  end

  // HIT shows the stunned pose (frame 0), FALL the falling pose (frame 3).
  always_comb begin
    case (state_q)
      HIT:     rom_frame = 5'd0;
      FALL:    rom_frame = 5'd3;
      default: rom_frame = {3'b000, frame_q};
    endcase
  end

  assign duck_x  = x_q;
  assign duck_y  = y_q;
  assign state   = state_q;
  assign fell    = fell_q;
  assign escaped = escaped_q;

  duck_pixel_pipe u_pixel_pipe (
    .clock       (clock),
    .reset       (reset),
    .active      (state_q != IDLE),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .duck_x      (x_q),
    .duck_y      (y_q),
    .rom_q       (rom_q),
    .rom_address (rom_address),
    .pixel_on    (pixel_on),
    .pixel_idx   (pixel_idx)
  );

endmodule

// File: tb/tb_duck_sprite_ctrl.sv
module tb_duck_sprite_ctrl;
  import duck_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start;
  logic        shot;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [3:0]  rom_q;
  logic [3:0]  rom_drive;
  logic [4:0]  rom_frame;
  logic [13:0] rom_address;
  logic        pixel_on;
  logic [3:0]  pixel_idx;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  duck_state_t state;
  logic        fell;
  logic        escaped;

  always #5 clock = ~clock;

  // Behavioural ROM: returns the index chosen for the address one cycle later.
  always @(posedge clock) rom_q <= rom_drive;

  duck_sprite_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .shot        (shot),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .rom_q       (rom_q),
    .rom_frame   (rom_frame),
    .rom_address (rom_address),
    .pixel_on    (pixel_on),
    .pixel_idx   (pixel_idx),
    .duck_x      (duck_x),
    .duck_y      (duck_y),
    .state       (state),
    .fell        (fell),
    .escaped     (escaped)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic       on;
    logic [3:0] idx;
    int         id;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [3:0]  q;
    logic [13:0] addr;
    logic        on;
    logic [3:0]  idx;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check($sformatf("pixel_on[v%0d]", e.id), 32'(pixel_on), 32'(e.on));
      check($sformatf("pixel_idx[v%0d]", e.id), 32'(pixel_idx), 32'(e.idx));
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_vec(input int id, input vec_t v);
    exp_t e;
    draw_x    = v.dx;
    draw_y    = v.dy;
    rom_drive = v.q;
    e.due = cyc + 2;
    e.on  = v.on;
    e.idx = v.idx;
    e.id  = id;
    sb.push_back(e);
    #1;
    check($sformatf("rom_address[v%0d]", id), 32'(rom_address), 32'(v.addr));
    step();
  endtask

  initial begin
    // Duck at (64,336) in FLY with no ticks yet.
    vecs[0] = '{10'd64,  10'd336, 4'd5, 14'd0,      1'b1, 4'd5};
    vecs[1] = '{10'd127, 10'd399, 4'd9, 14'h0FFF,   1'b1, 4'd9};
    vecs[2] = '{10'd128, 10'd336, 4'd5, 14'd0,      1'b0, 4'd0};
    vecs[3] = '{10'd63,  10'd336, 4'd5, 14'd63,     1'b0, 4'd0};
    vecs[4] = '{10'd70,  10'd340, 4'd0, 14'd262,    1'b0, 4'd0};
    vecs[5] = '{10'd64,  10'd335, 4'd7, 14'h0FC0,   1'b0, 4'd0};
    vecs[6] = '{10'd100, 10'd350, 4'd3, 14'd932,    1'b1, 4'd3};
    vecs[7] = '{10'd64,  10'd337, 4'd0, 14'd64,     1'b0, 4'd0};

    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; shot = 1'b0;
    draw_x = 10'd0; draw_y = 10'd0; rom_drive = 4'd0;
    step(); step();
    reset = 1'b0;
    step();

    check("reset_state", 32'(state), 32'(IDLE));
    check("reset_x", 32'(duck_x), 32'd64);
    check("reset_y", 32'(duck_y), 32'd336);
    check("reset_frame", 32'(rom_frame), 32'd0);
    check("reset_pixel_on", 32'(pixel_on), 32'd0);
    check("reset_pixel_idx", 32'(pixel_idx), 32'd0);
    check("reset_fell", 32'(fell), 32'd0);
    check("reset_escaped", 32'(escaped), 32'd0);

    // In IDLE the box is never hit even over the start position.
    drive_vec(100, '{10'd64, 10'd336, 4'd5, 14'd0, 1'b0, 4'd0});
    step(); step();

    // Scenario 1: start
    start = 1'b1; step(); start = 1'b0;
    check("s1_state", 32'(state), 32'(FLY));
    check("s1_x", 32'(duck_x), 32'd64);
    check("s1_y", 32'(duck_y), 32'd336);
    check("s1_frame", 32'(rom_frame), 32'd0);

    // Scenario 3: pixel path table
    for (int i = 0; i < 8; i++) drive_vec(i, vecs[i]);
    draw_x = 10'd0; draw_y = 10'd0; rom_drive = 4'd0;
    step(); step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    ticks(6);
    check("s1_frame_6", 32'(rom_frame), 32'd1);
    check("s1_x_6", 32'(duck_x), 32'd76);
    check("s1_y_6", 32'(duck_y), 32'd330);
    ticks(18);
    check("s1_frame_24", 32'(rom_frame), 32'd0);

    // Scenario 2: right wall then left wall
    ticks(231);
    check("s2_x_255", 32'(duck_x), 32'd574);
    check("s2_y_255", 32'(duck_y), 32'd81);
    check("s2_frame_255", 32'(rom_frame), 32'd2);
    tick();
    check("s2_x_bounce_r", 32'(duck_x), 32'd576);
    tick();
    check("s2_x_after_r", 32'(duck_x), 32'd574);
    ticks(287);
    check("s2_x_bounce_l", 32'(duck_x), 32'd0);
    check("s2_y_clamped", 32'(duck_y), 32'd0);
    tick();
    check("s2_x_after_l", 32'(duck_x), 32'd2);

    // Scenario 5: escape
    ticks(54);
    check("s5_fly_599", 32'(state), 32'(FLY));
    tick();
    check("s5_escape", 32'(state), 32'(ESCAPE));
    shot = 1'b1; step(); shot = 1'b0;
    check("s5_shot_ignored", 32'(state), 32'(ESCAPE));
    check("s5_escaped_early", 32'(escaped), 32'd0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("s5_idle", 32'(state), 32'(IDLE));
    check("s5_escaped_pulse", 32'(escaped), 32'd1);
    step();
    check("s5_escaped_clear", 32'(escaped), 32'd0);

    // Scenario 4: shot with tick
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    shot = 1'b1; frame_tick = 1'b1; step(); shot = 1'b0; frame_tick = 1'b0;
    check("s4_hit", 32'(state), 32'(HIT));
    check("s4_x_frozen", 32'(duck_x), 32'd64);
    check("s4_y_frozen", 32'(duck_y), 32'd336);
    start = 1'b1; step(); start = 1'b0;
    check("s4_start_ignored", 32'(state), 32'(HIT));
    ticks(29);
    check("s4_hit_29", 32'(state), 32'(HIT));
    check("s4_hit_frame", 32'(rom_frame), 32'd0);
    tick();
    check("s4_fall", 32'(state), 32'(FALL));
    check("s4_fall_frame", 32'(rom_frame), 32'd3);
    ticks(15);
    check("s4_y_396", 32'(duck_y), 32'd396);
    check("s4_still_fall", 32'(state), 32'(FALL));
    check("s4_no_fell_yet", 32'(fell), 32'd0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("s4_idle", 32'(state), 32'(IDLE));
    check("s4_y_ground", 32'(duck_y), 32'd400);
    check("s4_fell_pulse", 32'(fell), 32'd1);
    step();
    check("s4_fell_clear", 32'(fell), 32'd0);

    // Scenario 6: reset mid-FALL with a pixel in flight
    start = 1'b1; step(); start = 1'b0;
    shot = 1'b1; step(); shot = 1'b0;
    ticks(30);
    ticks(2);
    check("s6_fall", 32'(state), 32'(FALL));
    check("s6_y", 32'(duck_y), 32'd344);
    draw_x = 10'd64; draw_y = 10'd344; rom_drive = 4'd5;
    step();
    reset = 1'b1; step(); reset = 1'b0;
    draw_x = 10'd0; draw_y = 10'd0; rom_drive = 4'd0;
    check("s6_idle", 32'(state), 32'(IDLE));
    check("s6_x", 32'(duck_x), 32'd64);
    check("s6_y_start", 32'(duck_y), 32'd336);
    check("s6_pixel_on", 32'(pixel_on), 32'd0);
    check("s6_fell", 32'(fell), 32'd0);
    step();
    check("s6_fell_later", 32'(fell), 32'd0);
    check("s6_pixel_on_later", 32'(pixel_on), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
